eq_band_mixer: RTL

- Downstream consumer of the slide-pot interface.
- Takes five band-filtered audio samples (LP, B1, B2, B3, HP) and the six 12-bit pot values (five band gains plus VOLUME).
- Scales each band by its pot gain, sums the five bands, then applies VOLUME. Saturates the result to 16-bit signed.
- Uses one time-multiplexed multiplier driven by a small FSM. Output feeds the PWM/codec output stage.

---
 rtl/eq_band_mixer_if.sv | 53 +++++
 rtl/eq_band_mixer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/eq_band_mixer_if.sv
// eq_band_mixer_if -- sample-set / mixed-output bundle for eq_band_mixer.
//
// Optional macro: EQ_SAT_FLAG_EN adds the sat_flag signal.
//
// Signals:
//   seq_vld                      one-cycle strobe, new sample set present
//   lp_in, b1_in, b2_in,
//   b3_in, hp_in                 signed 16-bit band samples
//   POT_LP..POT_HP               unsigned 12-bit band gains
//   VOLUME                       unsigned 12-bit master volume
//   aud_out                      signed 16-bit mixed, volume-scaled sample
//   out_vld                      one-cycle pulse, aud_out updated
//   busy                         mixer is working on a sample set
//   sat_flag (EQ_SAT_FLAG_EN)    last result was clamped
// Modports: master = sample-set producer, slave = the mixer.
interface eq_band_mixer_if;
  logic               seq_vld;
  logic signed [15:0] lp_in;
  logic signed [15:0] b1_in;
  logic signed [15:0] b2_in;
  logic signed [15:0] b3_in;
  logic signed [15:0] hp_in;
  logic        [11:0] POT_LP;
  logic        [11:0] POT_B1;
  logic        [11:0] POT_B2;
  logic        [11:0] POT_B3;
  logic        [11:0] POT_HP;
  logic        [11:0] VOLUME;
  logic signed [15:0] aud_out;
  logic               out_vld;
  logic               busy;
`ifdef EQ_SAT_FLAG_EN
  logic               sat_flag;
`endif

  modport master (
    output seq_vld, lp_in, b1_in, b2_in, b3_in, hp_in,
    output POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME,
`ifdef EQ_SAT_FLAG_EN
    input  sat_flag,
`endif
    input  aud_out, out_vld, busy
  );

  modport slave (
    input  seq_vld, lp_in, b1_in, b2_in, b3_in, hp_in,
    input  POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME,
`ifdef EQ_SAT_FLAG_EN
    output sat_flag,
`endif
    output aud_out, out_vld, busy
  );
endinterface

// File: rtl/eq_band_mixer.sv
// eq_band_mixer -- five-band gain/sum/volume mixer with one shared multiplier.
//
// A sample set is latched on seq_vld while idle, then one band per cycle is
// multiplied by its pot gain and accumulated (MAC, 5 cycles), then the sum is
// multiplied by VOLUME and saturated to 16-bit signed (VOL, 1 cycle).
// Throughput: one sample set per 7 clocks.
//
// Optional macro: EQ_SAT_FLAG_EN adds bus.sat_flag (1 when the clamp was hit).
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    eq_band_mixer_if.slave (samples, pots, volume in; aud_out,
//          out_vld, busy [, sat_flag] out)
// Parameters:
//   GAIN_SHIFT  right shift after each band multiply (11..12, 0x800 = unity at 11)
//   VOL_SHIFT   right shift after the volume multiply (12..13)
module eq_band_mixer #(
  parameter int GAIN_SHIFT = 11,
  parameter int VOL_SHIFT  = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  eq_band_mixer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MAC, VOL} state_t;

  localparam logic signed [32:0] SAT_MAX = 33'sd32767;
  localparam logic signed [32:0] SAT_MIN = -33'sd32768;

  state_t state_reg, state_next;

  logic signed [15:0] sample_in  [5];
  logic        [11:0] pot_in     [5];
  logic signed [15:0] sample_reg [5];
  logic        [11:0] pot_reg    [5];
  logic        [11:0] vol_reg;
  logic        [2:0]  cnt_reg;
  logic signed [19:0] acc_reg;
  logic signed [15:0] aud_reg;
  logic               out_vld_reg;
  logic               busy_reg;

  assign sample_in[0] = bus.lp_in;
  assign sample_in[1] = bus.b1_in;
  assign sample_in[2] = bus.b2_in;
  assign sample_in[3] = bus.b3_in;
  assign sample_in[4] = bus.hp_in;
  assign pot_in[0]    = bus.POT_LP;
  assign pot_in[1]    = bus.POT_B1;
  assign pot_in[2]    = bus.POT_B2;
  assign pot_in[3]    = bus.POT_B3;
  assign pot_in[4]    = bus.POT_HP;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.seq_vld) state_next = MAC;
      MAC:     if (cnt_reg == 3'd4) state_next = VOL;
      VOL:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------- shared multiplier
  // Both operands are widened to the volume-path widths so one 20x13 signed
  // multiplier serves the band products and the volume product.
  logic signed [19:0] mul_a;
  logic signed [12:0] mul_b;
  logic signed [32:0] mul_p;
  logic signed [19:0] band_term;
  logic signed [32:0] vol_val;
  logic signed [15:0] sat_val;
  logic               sat_hit;

  always_comb begin
    mul_a = {{4{sample_reg[cnt_reg][15]}}, sample_reg[cnt_reg]};
    mul_b = $signed({1'b0, pot_reg[cnt_reg]});
    if (state_reg == VOL) begin
      mul_a = acc_reg;
      mul_b = $signed({1'b0, vol_reg});
    end
  end

  assign mul_p     = mul_a * mul_b;
  // Arithmetic shift floors toward -inf; the result always fits 20 bits.
  assign band_term = 20'(mul_p >>> GAIN_SHIFT);
  assign vol_val   = mul_p >>> VOL_SHIFT;

  always_comb begin
    sat_val = vol_val[15:0];
    sat_hit = 1'b0;
    if (vol_val > SAT_MAX) begin
      sat_val = 16'sh7FFF;
      sat_hit = 1'b1;
    end else if (vol_val < SAT_MIN) begin
      sat_val = 16'sh8000;
      sat_hit = 1'b1;
    end
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        sample_reg[i] <= '0;
        pot_reg[i]    <= '0;
      end
      vol_reg     <= '0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      aud_reg     <= '0;
      out_vld_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      out_vld_reg <= 1'b0;
      busy_reg    <= (state_next != IDLE);
      case (state_reg)
        IDLE: begin
          if (bus.seq_vld) begin
            for (int i = 0; i < 5; i++) begin
              sample_reg[i] <= sample_in[i];
              pot_reg[i]    <= pot_in[i];
            end
            vol_reg <= bus.VOLUME;
            acc_reg <= '0;
            cnt_reg <= '0;
          end
        end
        MAC: begin
          acc_reg <= acc_reg + band_term;
          cnt_reg <= (cnt_reg == 3'd4) ? 3'd0 : cnt_reg + 3'd1;
        end
        VOL: begin
          aud_reg     <= sat_val;
          out_vld_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.aud_out = aud_reg;
  assign bus.out_vld = out_vld_reg;
  assign bus.busy    = busy_reg;

`ifdef EQ_SAT_FLAG_EN
  logic sat_flag_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sat_flag_reg <= 1'b0;
    else if (state_reg == VOL) sat_flag_reg <= sat_hit;
  end
  assign bus.sat_flag = sat_flag_reg;
`else
  // Clamp indication is only exported when the flag port exists.
  logic sat_unused;
  assign sat_unused = sat_hit;
`endif

endmodule
